game_tick_scheduler: RTL and testbench

Per-frame update sequencer for the game logic. On each vertical-blank start from the HDMI timing generator it runs the player, ball and brick update units in a fixed order through independent req/ack handshakes, once every TICK_DIV frames. The sequence always finishes inside blanking so the renderer never sees a half-updated scene. It flags frame overruns and unresponsive units, and supports pause.

---
 rtl/game_tick_scheduler.sv | 162 ++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Per-frame game update sequencer: on vblank runs player, ball and brick
// update units in order via req/ack, with divider, timeout and overrun flags.
module game_tick_scheduler #(
    parameter int unsigned TICK_DIV       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic        pause,
    input  logic        clear_err,
    output logic        player_req,
    input  logic        player_ack,
    output logic        ball_req,
    input  logic        ball_ack,
    output logic        brick_req,
    input  logic        brick_ack,
    output logic        busy,
    output logic        tick_done,
    output logic [15:0] frame_count,
    output logic [15:0] tick_count,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAYER,
        S_BALL,
        S_BRICK,
        S_DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(TICK_DIV - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        vblank_q;
    logic [7:0]  div_q, div_d;
    logic [15:0] phase_q, phase_d;
    logic        req_q, req_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] tick_q, tick_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    logic frame_edge;
    logic idle;
    logic in_phase;
    logic phase_ack;
    logic phase_end;
    logic phase_to;
    logic start;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vblank_q  <= 1'b0;
            div_q     <= '0;
            phase_q   <= '0;
            req_q     <= 1'b0;
            frame_q   <= '0;
            tick_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblank_q  <= vblank;
            div_q     <= div_d;
            phase_q   <= phase_d;
            req_q     <= req_d;
            frame_q   <= frame_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        phase_ack = 1'b0;
        in_phase  = 1'b0;
        case (state_q)
            S_PLAYER: begin phase_ack = player_ack; in_phase = 1'b1; end
            S_BALL:   begin phase_ack = ball_ack;   in_phase = 1'b1; end
            S_BRICK:  begin phase_ack = brick_ack;  in_phase = 1'b1; end
            default:  begin phase_ack = 1'b0;       in_phase = 1'b0; end
        endcase
    end

    assign frame_edge = vblank & ~vblank_q;
    assign idle       = (state_q == S_IDLE);
    // An ack arriving on the final allowed cycle still counts as success.
    assign phase_end  = req_q & (phase_ack | (phase_q == TO_LAST));
    assign phase_to   = req_q & ~phase_ack & (phase_q == TO_LAST);
    assign start      = frame_edge & idle & ~pause & (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)     state_d = S_PLAYER;
            S_PLAYER: if (phase_end) state_d = S_BALL;
            S_BALL:   if (phase_end) state_d = S_BRICK;
            S_BRICK:  if (phase_end) state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_d     = in_phase & ~phase_end;
        phase_d   = phase_q;
        div_d     = div_q;
        frame_d   = frame_q;
        tick_d    = tick_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        // Phase counter only runs while the request is visible to the unit.
        if (state_d != state_q) begin
            phase_d = '0;
        end else if (req_q) begin
            phase_d = phase_q + 16'd1;
        end

        if (frame_edge & idle & ~pause) begin
            div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
        end

        if (frame_edge) begin
            frame_d = frame_q + 16'd1;
        end

        if (state_q == S_DONE) begin
            tick_d = tick_q + 16'd1;
        end

        if (frame_edge & ~idle) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end

        if (phase_to) begin
            timeout_d = 1'b1;
        end else if (clear_err) begin
            timeout_d = 1'b0;
        end
    end

    always_comb begin
        player_req  = req_q & (state_q == S_PLAYER);
        ball_req    = req_q & (state_q == S_BALL);
        brick_req   = req_q & (state_q == S_BRICK);
        busy        = ~idle;
        tick_done   = (state_q == S_DONE);
        frame_count = frame_q;
        tick_count  = tick_q;
        overrun     = overrun_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler (TICK_DIV=2, TIMEOUT_CYCLES=8).
module tb_game_tick_scheduler;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        vblank;
    logic        pause;
    logic        clear_err;
    logic        player_req, ball_req, brick_req;
    logic        player_ack, ball_ack, brick_ack;
    logic        busy, tick_done, overrun, timeout_err;
    logic [15:0] frame_count, tick_count;

    game_tick_scheduler #(
        .TICK_DIV(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50(clk),
        .rst_n(rst_n),
        .vblank(vblank),
        .pause(pause),
        .clear_err(clear_err),
        .player_req(player_req),
        .player_ack(player_ack),
        .ball_req(ball_req),
        .ball_ack(ball_ack),
        .brick_req(brick_req),
        .brick_ack(brick_ack),
        .busy(busy),
        .tick_done(tick_done),
        .frame_count(frame_count),
        .tick_count(tick_count),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int pl;
        int bl;
        int kl;
        int tc;
        int fc;
        int ovr;
        int to;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Unit models: ack once req has been high for dly+1 cycles.
    int dly_p = 0, dly_b = 0, dly_k = 0;
    int hp = 0, hb = 0, hk = 0;
    bit force_b = 0;

    always @(negedge clk) begin
        hp = player_req ? hp + 1 : 0;
        hb = ball_req ? hb + 1 : 0;
        hk = brick_req ? hk + 1 : 0;
        player_ack = player_req && (hp > dly_p);
        ball_ack   = force_b || (ball_req && (hb > dly_b));
        brick_ack  = brick_req && (hk > dly_k);
    end

    // Monitor: measures req windows and checks them on each tick_done.
    int pl = 0, bl = 0, kl = 0, ord = 0;
    bit ovl = 0, pend = 0, pp = 0, pb = 0, pk = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pl = 0; bl = 0; kl = 0; ord = 0;
            ovl = 0; pend = 0; pp = 0; pb = 0; pk = 0;
        end else begin
            if (pend) begin
                chk("post_tick_count", int'(tick_count), cur.tc);
                chk("post_frame_count", int'(frame_count), cur.fc);
                chk("post_overrun", int'(overrun), cur.ovr);
                chk("post_timeout_err", int'(timeout_err), cur.to);
                chk("post_busy", int'(busy), 0);
                pend = 0;
            end
            if (player_req && !pp) ord = ord * 4 + 1;
            if (ball_req && !pb) ord = ord * 4 + 2;
            if (brick_req && !pk) ord = ord * 4 + 3;
            pp = player_req; pb = ball_req; pk = brick_req;
            if (player_req) pl++;
            if (ball_req) bl++;
            if (brick_req) kl++;
            if (int'(player_req) + int'(ball_req) + int'(brick_req) > 1)
                ovl = 1;
            if (tick_done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tick: got tick_done, expected none");
                end else begin
                    cur = sb.pop_front();
                    chk("player_req_len", pl, cur.pl);
                    chk("ball_req_len", bl, cur.bl);
                    chk("brick_req_len", kl, cur.kl);
                    chk("req_order", ord, 27);
                    chk("req_overlap", int'(ovl), 0);
                    pend = 1;
                end
                pl = 0; bl = 0; kl = 0; ord = 0; ovl = 0;
            end
        end
    end

    bit watch = 0, saw = 0;
    always @(negedge clk)
        if (watch && (busy || player_req || ball_req || brick_req)) saw = 1;

    function automatic int rlen(input int d);
        return (d + 1 > TO) ? TO : d + 1;
    endfunction

    task automatic expect_seq(input int dp, input int db, input int dk,
                              input int tc, input int fc,
                              input int ovr, input int to);
        exp_t e;
        dly_p = dp; dly_b = db; dly_k = dk;
        e.pl = rlen(dp); e.bl = rlen(db); e.kl = rlen(dk);
        e.tc = tc; e.fc = fc; e.ovr = ovr; e.to = to;
        sb.push_back(e);
    endtask

    task automatic vbl();
        @(negedge clk);
        vblank = 1'b1;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait_expired", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; vblank = 1'b0; pause = 1'b0; clear_err = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_reqs", int'({player_req, ball_req, brick_req}), 0);
        chk("rst_tick_done", int'(tick_done), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_tick_count", int'(tick_count), 0);
        chk("rst_flags", int'({overrun, timeout_err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Divider: first edge only advances the divider.
        vbl();
        repeat (4) @(negedge clk);
        chk("div_first_edge_busy", int'(busy), 0);
        chk("div_first_edge_fc", int'(frame_count), 1);
        expect_seq(3, 3, 3, 1, 2, 0, 0);
        vbl();
        chk("start_busy", int'(busy), 1);
        wait_idle();

        expect_seq(0, 0, 0, 2, 4, 0, 0);
        vbl(); vbl();
        wait_idle();

        // Ball unit never answers: timeout, brick still runs.
        expect_seq(1, 255, 2, 3, 6, 0, 1);
        vbl(); vbl();
        wait_idle();
        force_b = 1;
        repeat (5) @(negedge clk);
        force_b = 0;
        chk("late_ack_busy", int'(busy), 0);
        chk("late_ack_tc", int'(tick_count), 3);
        chk("late_ack_to", int'(timeout_err), 1);
        pulse_clear();
        chk("clear_timeout", int'(timeout_err), 0);

        // Ack on the last allowed cycle is still a success.
        expect_seq(0, TO - 1, 0, 4, 8, 0, 0);
        vbl(); vbl();
        wait_idle();

        // Overrun: an edge while busy is flagged and not queued.
        expect_seq(6, 6, 6, 5, 11, 1, 0);
        vbl(); vbl();
        repeat (3) @(negedge clk);
        chk("busy_before_ovr", int'(busy), 1);
        vbl();
        wait_idle();
        pulse_clear();
        chk("clear_overrun", int'(overrun), 0);
        vbl();
        repeat (4) @(negedge clk);
        chk("ovr_edge_not_counted", int'(busy), 0);

        // clear_err coinciding with a new overrun edge: set wins.
        expect_seq(6, 6, 6, 6, 14, 1, 0);
        vbl();
        repeat (2) @(negedge clk);
        chk("busy_at_ovr_clear", int'(busy), 1);
        @(negedge clk);
        vblank = 1'b1; clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        vblank = 1'b0;
        wait_idle();
        pulse_clear();
        chk("clear_overrun2", int'(overrun), 0);

        // Pause blocks starts and holds the divider.
        pause = 1'b1; watch = 1; saw = 0;
        repeat (4) vbl();
        repeat (4) @(negedge clk);
        watch = 0;
        chk("pause_no_activity", int'(saw), 0);
        chk("pause_fc", int'(frame_count), 18);
        pause = 1'b0;
        vbl();
        repeat (4) @(negedge clk);
        chk("pause_div_held", int'(busy), 0);

        // Pause raised mid-sequence does not abort it.
        expect_seq(6, 2, 2, 7, 20, 0, 0);
        vbl();
        chk("pause_in_player", int'(player_req), 1);
        pause = 1'b1;
        wait_idle();
        pause = 1'b0;

        // Reset during the ball phase.
        dly_p = 3; dly_b = 20; dly_k = 3;
        vbl(); vbl();
        begin
            int n = 0;
            while (!ball_req && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_ball_phase", int'(ball_req), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ball_req", int'(ball_req), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_counts", int'(frame_count) + int'(tick_count), 0);
        chk("rst_mid_flags", int'({overrun, timeout_err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_seq(3, 3, 3, 1, 2, 0, 0);
        vbl(); vbl();
        wait_idle();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
